bus_rr_arbiter: RTL and testbench

- Round-robin bus arbiter sharing one slave bus among NUM_M masters.
- Grants exactly one master at a time and drives a one-hot slave select decoded from that master's slave_id.
- Holds the grant until the slave's ack falls (end of transfer), with optional bus lock and a watchdog timeout.
- Sits between the master request ports and the shared slave mux/decoder.

---
 rtl/bus_arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 56 +++++
 rtl/bus_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, defaults and helpers for the round-robin bus arbiter
//
// Purpose : state encoding, default parameter values, one-hot decode and
//           round-robin start-index helper used by bus_rr_arbiter and rr_pick.
// Ports   : none (package).
package bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NUM_M  = 3;
    localparam int DEF_NUM_S  = 2;
    localparam int DEF_SID_W  = 1;
    localparam int DEF_TO_CYC = 16;
    localparam int DEF_TO_W   = 5;

    // Indices of 32 or more decode to all-zero, which is what makes an
    // out-of-range slave id produce an empty select.
    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

    // First index examined after 'last' in rotating order.
    function automatic int rr_next(input int last, input int n);
        rr_next = (last + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//
// Purpose : returns the first eligible requester after i_last in
//           round-robin order; masters in i_excl are never chosen.
// Ports   : i_req    [NUM_M-1:0] request vector
//           i_last   [2:0]       index granted most recently
//           i_excl   [NUM_M-1:0] masters excluded from this pick
//           o_valid              an eligible requester exists
//           o_winner [2:0]       index of the chosen requester
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [2:0]       i_last,
    input  logic [NUM_M-1:0] i_excl,
    output logic             o_valid,
    output logic [2:0]       o_winner
);

    logic [NUM_M-1:0] w_elig;
    int               w_start;
    logic             w_hi_v;
    logic             w_lo_v;
    logic [2:0]       w_hi;
    logic [2:0]       w_lo;

    assign w_elig  = i_req & ~i_excl;
    assign w_start = rr_next(int'(i_last), NUM_M);

    // Split eligible masters into those at/after the rotation start (hi) and
    // those before it (lo); a descending scan leaves the lowest index of each
    // group, and the hi group wins because it comes first in rotation.
    always_comb begin
        w_hi_v = 1'b0;
        w_lo_v = 1'b0;
        w_hi   = '0;
        w_lo   = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                if (i >= w_start) begin
                    w_hi_v = 1'b1;
                    w_hi   = 3'(i);
                end else begin
                    w_lo_v = 1'b1;
                    w_lo   = 3'(i);
                end
            end
        end
    end

    assign o_valid  = w_hi_v | w_lo_v;
    assign o_winner = w_hi_v ? w_hi : w_lo;

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one slave bus among NUM_M masters
//
// Purpose : grants one master at a time, decodes its slave id into a one-hot
//           slave select, holds the grant until ack falls, supports per-master
//           bus lock and an optional watchdog (macro BUS_RR_ARBITER_TIMEOUT_EN).
// Ports   : i_clk                     rising-edge clock
//           i_rst                     asynchronous active-high reset
//           i_req      [NUM_M-1:0]    level request per master
//           i_lock     [NUM_M-1:0]    per-master lock, sampled at transfer end
//           i_slave_id [NUM_M*SID_W-1:0] target slave per master
//           i_ack                     slave ack; transfer ends on its fall
//           o_gnt      [NUM_M-1:0]    registered one-hot grant
//           o_sel      [NUM_S-1:0]    registered one-hot slave select
//           o_busy                    a grant is held
//           o_owner    [2:0]          current grantee, 0 when idle
//           o_timeout                 one-cycle pulse on a watchdog release
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_M  = DEF_NUM_M,
    parameter int NUM_S  = DEF_NUM_S,
    parameter int SID_W  = DEF_SID_W,
    parameter int TO_CYC = DEF_TO_CYC,
    parameter int TO_W   = DEF_TO_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_M-1:0]       i_req,
    input  logic [NUM_M-1:0]       i_lock,
    input  logic [NUM_M*SID_W-1:0] i_slave_id,
    input  logic                   i_ack,
    output logic [NUM_M-1:0]       o_gnt,
    output logic [NUM_S-1:0]       o_sel,
    output logic                   o_busy,
    output logic [2:0]             o_owner,
    output logic                   o_timeout
);

    if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
        $error("bus_rr_arbiter: NUM_M must be in 2..8");
    end
    if (TO_W < $clog2(TO_CYC + 1)) begin : g_bad_to_w
        $error("bus_rr_arbiter: TO_W too narrow for TO_CYC");
    end

    state_t           r_state;
    logic [NUM_M-1:0] r_gnt;
    logic [NUM_S-1:0] r_sel;
    logic [2:0]       r_owner;
    logic [2:0]       r_last;
    logic             r_busy;
    logic             r_timeout;
    logic             r_ack_r;

    logic             w_is_busy;
    logic             w_done;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_abandon;
    logic             w_wd_fire;
    logic             w_keep;
    logic             w_release;
    logic             w_do_grant;
    logic             w_go_idle;
    logic             w_pick_v;
    logic [2:0]       w_pick;
    logic [2:0]       w_tgt;
    logic [SID_W-1:0] w_tgt_sid;
    logic [NUM_M-1:0] w_gnt_next;
    logic [NUM_S-1:0] w_sel_next;

    assign w_is_busy = (r_state == BUSY);
    assign w_done    = r_ack_r & ~i_ack;

    // r_gnt is the owner's one-hot mask while busy and zero while idle, so
    // it doubles as the owner selector and as the picker's exclude mask.
    assign w_own_req  = |(i_req & r_gnt);
    assign w_own_lock = |(i_lock & r_gnt);
    assign w_abandon  = w_is_busy & ~w_own_req & ~i_ack & ~r_ack_r;

    assign w_keep     = w_is_busy & w_done & w_own_lock & w_own_req;
    assign w_release  = w_is_busy & (w_done | w_abandon | w_wd_fire) & ~w_keep;

    rr_pick #(
        .NUM_M    (NUM_M)
    ) u_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .i_excl   (r_gnt),
        .o_valid  (w_pick_v),
        .o_winner (w_pick)
    );

    // A kept lock or a release with no other requester re-grants the owner.
    assign w_tgt      = (w_keep || !w_pick_v) ? r_owner : w_pick;
    assign w_do_grant = (!w_is_busy && w_pick_v) || w_keep ||
                        (w_release && (w_pick_v || w_own_req));
    assign w_go_idle  = w_release && !w_pick_v && !w_own_req;

    always_comb begin
        w_tgt_sid = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (w_tgt == 3'(m)) begin
                w_tgt_sid = i_slave_id[m*SID_W +: SID_W];
            end
        end
    end

    assign w_gnt_next = NUM_M'(onehot(32'(w_tgt)));
    assign w_sel_next = NUM_S'(onehot(32'(w_tgt_sid)));

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    logic [TO_W-1:0] r_wd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd <= '0;
        end else if (!w_is_busy || w_keep || w_release) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // A genuine transfer end in the same cycle takes precedence over the dog.
    assign w_wd_fire = w_is_busy & (r_wd == TO_W'(TO_CYC - 1)) & ~w_done;
`else
    assign w_wd_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_owner   <= '0;
            r_last    <= 3'(NUM_M - 1);
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ack_r   <= 1'b0;
        end else begin
            // ack history runs across grant switches on purpose.
            r_ack_r   <= i_ack;
            r_timeout <= w_release & w_wd_fire;
            if (w_do_grant) begin
                r_state <= BUSY;
                r_gnt   <= w_gnt_next;
                r_sel   <= w_sel_next;
                r_owner <= w_tgt;
                r_last  <= w_tgt;
                r_busy  <= 1'b1;
            end else if (w_go_idle) begin
                r_state <= IDLE;
                r_gnt   <= '0;
                r_sel   <= '0;
                r_owner <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_gnt     = r_gnt;
    assign o_sel     = r_sel;
    assign o_busy    = r_busy;
    assign o_owner   = r_owner;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] slave_id;
    logic       ack;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [2:0] owner;
    logic       timeout;

    int n_chk  = 0;
    int n_pass = 0;

    bus_rr_arbiter u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_lock     (lock),
        .i_slave_id (slave_id),
        .i_ack      (ack),
        .o_gnt      (gnt),
        .o_sel      (sel),
        .o_busy     (busy),
        .o_owner    (owner),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ack high for one cycle; on return ack has just fallen, so the next
    // rising edge sees done.
    task automatic ack_pulse();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [2:0] g, input logic [1:0] s,
                                input logic b, input logic [2:0] o);
        check({tag, ".gnt"},   32'(gnt),   32'(g));
        check({tag, ".sel"},   32'(sel),   32'(s));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".owner"}, 32'(owner), 32'(o));
    endtask

    initial begin
        rst      = 1'b1;
        req      = 3'b000;
        lock     = 3'b000;
        slave_id = 3'b010;
        ack      = 1'b0;
        cyc(2);
        expect_state("reset", 3'b000, 2'b00, 1'b0, 3'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        cyc(1);
        expect_state("post_reset", 3'b000, 2'b00, 1'b0, 3'd0);

        // Rotation 0,1,2,0 with m1 targeting slave 1, others slave 0.
        req = 3'b111;
        cyc(1);
        expect_state("rot0", 3'b001, 2'b01, 1'b1, 3'd0);
        ack_pulse(); cyc(1);
        expect_state("rot1", 3'b010, 2'b10, 1'b1, 3'd1);
        ack_pulse(); cyc(1);
        expect_state("rot2", 3'b100, 2'b01, 1'b1, 3'd2);
        ack_pulse(); cyc(1);
        expect_state("rot3", 3'b001, 2'b01, 1'b1, 3'd0);
        req = 3'b000;
        cyc(1);
        expect_state("rot_idle", 3'b000, 2'b00, 1'b0, 3'd0);

        // Slave id latched at grant and held through the tenure.
        req      = 3'b010;
        slave_id = 3'b010;
        cyc(1);
        expect_state("sid_grant", 3'b010, 2'b10, 1'b1, 3'd1);
        slave_id = 3'b000;
        cyc(2);
        check("sid_hold.sel", 32'(sel), 32'h2);
        req = 3'b000;
        cyc(1);
        check("sid_idle.gnt", 32'(gnt), 32'd0);

        // Lock: last=1, req=011 -> m0 first; lock holds it across one ack.
        slave_id = 3'b010;
        req      = 3'b011;
        lock     = 3'b001;
        cyc(1);
        expect_state("lock_grant", 3'b001, 2'b01, 1'b1, 3'd0);
        ack_pulse(); cyc(1);
        expect_state("lock_keep", 3'b001, 2'b01, 1'b1, 3'd0);
        lock = 3'b000;
        ack_pulse(); cyc(1);
        expect_state("lock_drop", 3'b010, 2'b10, 1'b1, 3'd1);
        // Owner is the only requester: re-granted with no idle cycle.
        req = 3'b010;
        ack_pulse(); cyc(1);
        expect_state("regrant", 3'b010, 2'b10, 1'b1, 3'd1);
        req = 3'b000;
        cyc(1);
        expect_state("regrant_idle", 3'b000, 2'b00, 1'b0, 3'd0);

        // Abandon by m2, then pointer last=2 makes m0 win on req=111.
        req = 3'b100;
        cyc(1);
        expect_state("m2_grant", 3'b100, 2'b01, 1'b1, 3'd2);
        req = 3'b000;
        cyc(1);
        expect_state("abandon", 3'b000, 2'b00, 1'b0, 3'd0);
        req = 3'b111;
        cyc(1);
        expect_state("after_abandon", 3'b001, 2'b01, 1'b1, 3'd0);

        // Watchdog: m0 holds with no ack activity, m1 waiting.
        req = 3'b011;
`ifdef BUS_RR_ARBITER_TIMEOUT_EN
        cyc(15);
        check("wd_pre.gnt", 32'(gnt), 32'h1);
        check("wd_pre.timeout", 32'(timeout), 32'd0);
        cyc(1);
        check("wd_fire.gnt", 32'(gnt), 32'h2);
        check("wd_fire.timeout", 32'(timeout), 32'd1);
        cyc(1);
        check("wd_post.timeout", 32'(timeout), 32'd0);
        check("wd_post.gnt", 32'(gnt), 32'h2);
`else
        cyc(110);
        check("no_wd.gnt", 32'(gnt), 32'h1);
        check("no_wd.timeout", 32'(timeout), 32'd0);
`endif
        req = 3'b000;
        cyc(1);
        check("wd_idle.busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-tenure.
        req = 3'b100;
        cyc(1);
        check("ar_grant.gnt", 32'(gnt), 32'h4);
        #2 rst = 1'b1;
        #1;
        expect_state("ar_async", 3'b000, 2'b00, 1'b0, 3'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        expect_state("ar_regrant", 3'b100, 2'b01, 1'b1, 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
